// File: rtl/assertion_pkg.sv
// Shared definitions for the assertion monitor bank: readout address map
// (byte addresses, word aligned) and the readout handshake state type.
package assertion_pkg;

  localparam logic [31:0] ADDR_STATUS   = 32'h0000_0000;
  localparam logic [31:0] ADDR_FIRST    = 32'h0000_0004;
  localparam logic [31:0] ADDR_NUMCFG   = 32'h0000_0008;
  localparam logic [31:0] ADDR_TSTAMP   = 32'h0000_000C;
  localparam logic [31:0] ADDR_CNT_BASE = 32'h0000_0100;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/assert_sat_counter.sv
// Saturating event counter for one assertion channel.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (count -> 0)
//   clr_i  synchronous clear, wins over inc_i
//   inc_i  count one event this cycle
//   cnt_o  current count, holds at all-ones instead of wrapping
module assert_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/assertion_monitor_bank.sv
// Multi-channel assertion monitor: per-channel saturating fire counters, a
// sticky aggregate failure flag, first-failing-channel capture and a
// word-addressed 4-phase req/ack readout port.
// Optional feature macro: ASSERT_TIMESTAMP_EN adds a free-running cycle
// counter whose value is captured with the first failure (read at 0x00C).
// Ports:
//   assert_clk        clock
//   assert_rst        asynchronous active-high reset
//   assert_fire       per-channel failure strobe
//   assert_mask       per-channel enable for assert_fire
//   assert_clr        synchronous clear of counters, flag and capture
//   cnt_addr          readout byte address, bits [1:0] ignored
//   cnt_req           readout request level
//   cnt_ack           readout acknowledge level
//   cnt_data          readout data, stable while cnt_ack=1
//   assertion_failed  sticky: an enabled channel fired since reset/clear
module assertion_monitor_bank
  import assertion_pkg::*;
#(
  parameter int unsigned NUM_ASSERT = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TS_W       = 32
) (
  input  logic                  assert_clk,
  input  logic                  assert_rst,
  input  logic [NUM_ASSERT-1:0] assert_fire,
  input  logic [NUM_ASSERT-1:0] assert_mask,
  input  logic                  assert_clr,
  input  logic [31:0]           cnt_addr,
  input  logic                  cnt_req,
  output logic                  cnt_ack,
  output logic [31:0]           cnt_data,
  output logic                  assertion_failed
);

  if (NUM_ASSERT < 1 || NUM_ASSERT > 256) begin : g_bad_num
    $error("NUM_ASSERT out of range 1..256");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $error("CNT_W out of range 1..32");
  end
  if (TS_W < 1 || TS_W > 32) begin : g_bad_ts
    $error("TS_W out of range 1..32");
  end

  logic [NUM_ASSERT-1:0] hit;
  logic [CNT_W-1:0]      cnt_val [NUM_ASSERT];

  assign hit = assert_fire & assert_mask;

  for (genvar g = 0; g < NUM_ASSERT; g++) begin : g_cnt
    assert_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i (assert_clk),
      .rst_i (assert_rst),
      .clr_i (assert_clr),
      .inc_i (hit[g]),
      .cnt_o (cnt_val[g])
    );
  end

  // Sticky flag and first-fail capture
  logic       failed_q, failed_d;
  logic       first_vld_q, first_vld_d;
  logic [7:0] first_idx_q, first_idx_d;
  logic [7:0] low_idx;
  logic       capture;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NUM_ASSERT; i > 0; i--) begin
      if (hit[i-1]) begin
        low_idx = 8'(i - 1);
      end
    end
  end

  assign capture = !assert_clr && !first_vld_q && (|hit);

  always_comb begin
    failed_d    = failed_q;
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    if (assert_clr) begin
      failed_d    = 1'b0;
      first_vld_d = 1'b0;
      first_idx_d = '0;
    end else begin
      if (|hit) begin
        failed_d = 1'b1;
      end
      if (capture) begin
        first_vld_d = 1'b1;
        first_idx_d = low_idx;
      end
    end
  end

  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      failed_q    <= 1'b0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      failed_q    <= failed_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign assertion_failed = failed_q;

  // First-fail timestamp
  logic [31:0] tstamp_word;

`ifdef ASSERT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_free_q;
  logic [TS_W-1:0] ts_first_q, ts_first_d;

  // Free-running and deliberately untouched by assert_clr.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      ts_free_q <= '0;
    end else begin
      ts_free_q <= ts_free_q + 1'b1;
    end
  end

  always_comb begin
    ts_first_d = ts_first_q;
    if (assert_clr) begin
      ts_first_d = '0;
    end else if (capture) begin
      ts_first_d = ts_free_q;
    end
  end

  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      ts_first_q <= '0;
    end else begin
      ts_first_q <= ts_first_d;
    end
  end

  assign tstamp_word = 32'(ts_first_q);
`else
  assign tstamp_word = '0;
`endif

  // Readout word decode
  logic [31:0] addr_w;
  logic [31:0] cnt_off;
  logic [31:0] cnt_idx;
  logic [31:0] rd_word;

  assign addr_w  = cnt_addr & ~32'h3;
  assign cnt_off = addr_w - ADDR_CNT_BASE;
  assign cnt_idx = cnt_off >> 2;

  always_comb begin
    rd_word = '0;
    case (addr_w)
      ADDR_STATUS: rd_word = {30'b0, first_vld_q, failed_q};
      ADDR_FIRST:  rd_word = {24'b0, first_idx_q};
      ADDR_NUMCFG: rd_word = {8'b0, 8'(CNT_W), 16'(NUM_ASSERT)};
      ADDR_TSTAMP: rd_word = tstamp_word;
      default: begin
        if (addr_w >= ADDR_CNT_BASE) begin
          for (int unsigned i = 0; i < NUM_ASSERT; i++) begin
            if (cnt_idx == i) begin
              rd_word = 32'(cnt_val[i]);
            end
          end
        end
      end
    endcase
  end

  // Readout handshake FSM
  rd_state_e   state_q, state_d;
  logic        rd_load;
  logic [31:0] data_q;

  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_req)  state_d = RESP;
      RESP:    if (!cnt_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_ack = (state_q == RESP);
    rd_load = (state_q == IDLE) && cnt_req;
  end

  // Snapshot taken only on acceptance; address changes during RESP are ignored.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      data_q <= '0;
    end else if (rd_load) begin
      data_q <= rd_word;
    end
  end

  assign cnt_data = data_q;

endmodule

// File: tb/tb_assertion_monitor_bank.sv
module tb_assertion_monitor_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fire, mask;
  logic        clr;
  logic [31:0] addr;
  logic        req0, req4;
  logic        ack0, ack4, af0, af4;
  logic [31:0] data0, data4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] e;
  } rd_t;

  rd_t q0[$];
  rd_t q4[$];

  always #5 clk = ~clk;

  assertion_monitor_bank u_dut (
    .assert_clk       (clk),
    .assert_rst       (rst),
    .assert_fire      (fire),
    .assert_mask      (mask),
    .assert_clr       (clr),
    .cnt_addr         (addr),
    .cnt_req          (req0),
    .cnt_ack          (ack0),
    .cnt_data         (data0),
    .assertion_failed (af0)
  );

  assertion_monitor_bank #(
    .CNT_W (4)
  ) u_d4 (
    .assert_clk       (clk),
    .assert_rst       (rst),
    .assert_fire      (fire),
    .assert_mask      (mask),
    .assert_clr       (clr),
    .cnt_addr         (addr),
    .cnt_req          (req4),
    .cnt_ack          (ack4),
    .cnt_data         (data4),
    .assertion_failed (af4)
  );

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endfunction

  // Monitor: compares the data presented on every rising acknowledge.
  logic ack0_d = 1'b0;
  logic ack4_d = 1'b0;
  always @(negedge clk) begin
    rd_t r;
    if (ack0 && !ack0_d) begin
      if (q0.size() == 0) begin
        total_cnt++;
        $display("FAIL rd0 unexpected ack: data %h", data0);
      end else begin
        r = q0.pop_front();
        chk($sformatf("rd0 @%h", r.a), data0, r.e);
      end
    end
    if (ack4 && !ack4_d) begin
      if (q4.size() == 0) begin
        total_cnt++;
        $display("FAIL rd4 unexpected ack: data %h", data4);
      end else begin
        r = q4.pop_front();
        chk($sformatf("rd4 @%h", r.a), data4, r.e);
      end
    end
    ack0_d = ack0;
    ack4_d = ack4;
  end

  task automatic rd(input bit w, input logic [31:0] a, input logic [31:0] e);
    rd_t r;
    r.a = a;
    r.e = e;
    if (w) q4.push_back(r); else q0.push_back(r);
    @(posedge clk); #1;
    addr = a;
    if (w) req4 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    chk("ack latency", w ? ack4 : ack0, 1'b1);
    if (w) req4 = 1'b0; else req0 = 1'b0;
    for (int i = 0; i < 8 && (w ? ack4 : ack0); i++) begin
      @(posedge clk); #1;
    end
    chk("ack release", w ? ack4 : ack0, 1'b0);
  endtask

  task automatic pulse(input logic [31:0] v, input int n, input bit c);
    @(posedge clk); #1;
    fire = v;
    clr  = c;
    repeat (n) @(posedge clk);
    #1;
    fire = '0;
    clr  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    fire = '0;
    mask = '1;
    clr  = 1'b0;
    addr = '0;
    req0 = 1'b0;
    req4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and constant registers
    chk("af after reset", af0, 1'b0);
    chk("ack after reset", ack0, 1'b0);
    rd(0, 32'h000, 32'h0);
    rd(0, 32'h008, 32'h0010_0020);
    rd(1, 32'h008, 32'h0004_0020);
    rd(0, 32'h00C, 32'h0);
    rd(0, 32'h180, 32'h0);
    rd(0, 32'h200, 32'h0);

    // Three pulses on channel 5
    @(posedge clk); #1;
    fire[5] = 1'b1;
    chk("af before first hit", af0, 1'b0);
    @(posedge clk); #1;
    chk("af after first hit", af0, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    fire = '0;
    rd(0, 32'h114, 32'd3);
    rd(0, 32'h116, 32'd3);
    rd(0, 32'h000, 32'h3);
    rd(0, 32'h004, 32'd5);

    // Simultaneous hits: lowest index wins, capture then sticks
    pulse(32'h0, 1, 1'b1);
    chk("af after clr", af0, 1'b0);
    pulse(32'h0000_0204, 1, 1'b0);
    rd(0, 32'h004, 32'd2);
    rd(0, 32'h124, 32'd1);
    rd(0, 32'h108, 32'd1);
    pulse(32'h0000_0001, 1, 1'b0);
    rd(0, 32'h004, 32'd2);
    rd(0, 32'h100, 32'd1);

    // Masked channel is ignored entirely
    pulse(32'h0, 1, 1'b1);
    mask = ~32'h80;
    pulse(32'h80, 10, 1'b0);
    chk("af masked", af0, 1'b0);
    rd(0, 32'h11C, 32'd0);
    rd(0, 32'h000, 32'h0);
    mask = '1;

    // Saturation at CNT_W=4, and clear beating a same-cycle hit
    pulse(32'h0, 1, 1'b1);
    pulse(32'h1, 20, 1'b0);
    rd(1, 32'h100, 32'd15);
    rd(0, 32'h100, 32'd20);
    rd(1, 32'h000, 32'h3);
    pulse(32'h1, 1, 1'b1);
    rd(1, 32'h100, 32'd0);
    rd(1, 32'h000, 32'h0);
    rd(0, 32'h000, 32'h0);
    rd(0, 32'h004, 32'h0);

    // Snapshot held across address change, then reset mid-response
    pulse(32'h20, 3, 1'b0);
    begin
      rd_t r;
      r.a = 32'h114;
      r.e = 32'd3;
      q0.push_back(r);
    end
    @(posedge clk); #1;
    addr = 32'h114;
    req0 = 1'b1;
    @(posedge clk); #1;
    chk("snapshot ack", ack0, 1'b1);
    addr = 32'h000;
    @(posedge clk);
    @(posedge clk); #1;
    chk("snapshot hold", data0, 32'd3);
    chk("snapshot ack held", ack0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("ack async reset", ack0, 1'b0);
    chk("data async reset", data0, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(0, 32'h000, 32'h0);
    rd(0, 32'h114, 32'h0);

    repeat (4) @(posedge clk);
    if (q0.size() != 0 || q4.size() != 0) begin
      total_cnt++;
      $display("FAIL pending reads: %0d/%0d never acked", q0.size(), q4.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
